// File: rtl/mux_nx1_rr.sv
// N-channel, W-bit multiplexer with a registered output and valid/ready
// handshakes. mode=0 follows the external sel; mode=1 arbitrates
// round-robin among the valid channels, starting the search at ptr.
// SELW must equal $clog2(N).
module mux_nx1_rr #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_ch
);

  // Output register state and round-robin pointer
  logic [W-1:0]    data_p1;
  logic            vld_p1;
  logic [SELW-1:0] ch_p1;
  logic [SELW-1:0] ptr;

  // Grant and handshake signals
  logic            rr_grant;
  logic [SELW-1:0] rr_g;
  logic            fx_grant;
  logic            grant;
  logic [SELW-1:0] g;
  logic            load_en;
  logic            accept;
  logic [W-1:0]    sel_data;
  logic [SELW-1:0] ptr_next;
  logic [SELW-1:0] idx;

  // Round-robin search: the lowest offset from ptr with a valid channel wins.
  // The loop runs from the far end down so the nearest candidate is the
  // last assignment.
  always_comb begin
    rr_grant = 1'b0;
    rr_g     = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = SELW'((int'(ptr) + k) % N);
      if (in_valid[idx]) begin
        rr_grant = 1'b1;
        rr_g     = idx;
      end
    end
  end

  // Fixed-mode grant and final grant/accept selection. sel values at or
  // beyond N (possible when N is not a power of two) never grant.
  always_comb begin
    fx_grant = (int'(sel) < N) ? in_valid[sel] : 1'b0;
    grant    = mode ? rr_grant : fx_grant;
    g        = mode ? rr_g : sel;
    load_en  = !vld_p1 || out_ready;
    accept   = grant && load_en && !rst;
    sel_data = in_data[int'(g) * W +: W];
    ptr_next = (int'(g) == N - 1) ? '0 : g + 1'b1;
  end

  // in_ready is one-hot on the granted channel only when a load can happen
  always_comb begin
    in_ready = '0;
    if (accept) in_ready[g] = 1'b1;
  end

  // ---- stage p1: output register, drain/overwrite, pointer advance ----
  // Output register update: accept overwrites (even while draining),
  // otherwise a drain empties the register but keeps data/ch.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= sel_data;
        ch_p1   <= g;
        if (mode) ptr <= ptr_next;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: a reference model predicts grants and
// pushes expected words into a queue; a monitor pops them as the DUT hands
// words downstream.
module tb_mux_nx1_rr;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SELW-1:0]   out_ch;

  typedef struct {
    logic [W-1:0]    d;
    logic [SELW-1:0] ch;
  } word_t;

  word_t exp_q[$];
  int    nchk = 0;
  int    nerr = 0;

  // model state
  bit    mvalid = 0;
  int    mptr   = 0;

  always #5 clk = ~clk;

  mux_nx1_rr #(.N(N), .W(W), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  // Reference model: mid-cycle, predict what the next edge will do.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit gv;
    bit ld;
    int g;
    int c;
    word_t w;
    nchk++;
    if (out_valid !== mvalid) begin
      nerr++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, mvalid, $time);
    end
    gv = 0;
    g  = 0;
    if (!rst) begin
      if (mode == 1'b0) begin
        if (int'(sel) < N && in_valid[sel]) begin gv = 1; g = int'(sel); end
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (mptr + k) % N;
          if (!gv && in_valid[c]) begin gv = 1; g = c; end
        end
      end
    end
    ld      = !mvalid || out_ready;
    exp_rdy = (gv && ld) ? N'(1 << g) : '0;
    nchk++;
    if (in_ready !== exp_rdy) begin
      nerr++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
    end
    if (rst) begin
      mvalid = 0;
      mptr   = 0;
      exp_q.delete();
    end else if (gv && ld) begin
      w.d  = in_data[g*W +: W];
      w.ch = SELW'(g);
      exp_q.push_back(w);
      mvalid = 1;
      if (mode) mptr = (g + 1) % N;
    end else if (out_ready) begin
      mvalid = 0;
    end
  end

  // Monitor: compare each word as downstream takes it; check hold stability.
  bit              hold_prev = 0;
  logic [W-1:0]    prev_d;
  logic [SELW-1:0] prev_ch;
  always @(negedge clk) begin
    word_t w;
    if (hold_prev) begin
      nchk++;
      if (out_data !== prev_d || out_ch !== prev_ch) begin
        nerr++;
        $display("FAIL hold: got %h/%0d want %h/%0d at %0t", out_data, out_ch, prev_d, prev_ch, $time);
      end
    end
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL word: got %h/%0d want none (queue empty) at %0t", out_data, out_ch, $time);
      end else begin
        w = exp_q.pop_front();
        if (out_data !== w.d || out_ch !== w.ch) begin
          nerr++;
          $display("FAIL word: got %h/%0d want %h/%0d at %0t", out_data, out_ch, w.d, w.ch, $time);
        end
      end
    end
    hold_prev = !rst && out_valid === 1'b1 && out_ready === 1'b0;
    prev_d    = out_data;
    prev_ch   = out_ch;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data_rr();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'hA0 + i);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_data_rr();

    // Reset: register contents cleared while rst is held
    repeat (2) begin
      @(negedge clk);
      nchk++;
      if (out_data !== '0 || out_ch !== '0) begin
        nerr++;
        $display("FAIL reset_regs: got %h/%0d want 00/0", out_data, out_ch);
      end
    end
    step();
    rst = 1'b0;

    // Round-robin fairness, all valid
    repeat (8) step();

    // Fixed mode stepping sel with alternating 0/1 data
    mode = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i % 2);
    sel = 0;
    for (int s = 1; s < N; s++) begin
      step();
      sel = SELW'(s);
    end
    step();

    // Sparse with wrap: only channels 1 and 3
    mode     = 1'b1;
    set_data_rr();
    in_valid = 4'b1010;
    repeat (5) step();

    // Backpressure then simultaneous drain and load
    in_valid = 4'b0001;
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (2) step();

    // Fixed sel on an invalid channel: no accept, output drains
    mode     = 1'b0;
    sel      = 2;
    in_valid = 4'b1011;
    repeat (3) step();

    // Reset while a word is held
    sel = 0;
    step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      in_valid  = N'($urandom);
      mode      = 1'($urandom);
      sel       = SELW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      step();
    end

    // Drain everything
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d words left want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-channel, W-bit multiplexer with a registered output, valid/ready handshakes on every port, and two selection modes. Fixed mode follows an external select. Round-robin mode arbitrates fairly among the valid channels. It generalises the combinational 4x1 mux and is used wherever several producers share one downstream consumer.

## Interface
- N, 4: number of input channels, 2..16.
- W, 8: data width per channel, 1..64.
- SELW, 2: select and channel-ID width. Must equal $clog2(N).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready. One-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode. Ignored in round-robin mode.
- out_data  output  W  registered data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_ch  output  SELW  index of the channel that supplied out_data.

## Operation
- The block has one output register, with state out_valid/out_data/out_ch.
- load_en = !out_valid | out_ready. This is combinational.
- Grant g is combinational and at most one channel is granted per cycle.
  - Fixed mode: g = sel when in_valid[sel] is set and sel < N. Otherwise there is no grant.
  - Round-robin mode: g is the first i with in_valid[i] set, searching from ptr upward and wrapping at N-1 to 0. If no input is valid, there is no grant.
- in_ready[g] = load_en when a grant exists. All other in_ready bits are 0. in_ready does not depend on in_valid of other channels beyond grant selection.
- Accept happens when in_valid[g] and in_ready[g] are both set. On accept:
  - out_data <= in_data[g].
  - out_ch <= g.
  - out_valid <= 1.
- Output drain: when out_valid and out_ready are set and no accept occurs, out_valid <= 0. out_data and out_ch keep their values.
- Simultaneous drain and accept: the register is overwritten with the new word and out_valid stays 1. This gives full throughput of 1 word per cycle.
- Hold: when out_valid is set and out_ready is clear, out_data and out_ch stay stable and every in_ready bit is 0.
- ptr is a SELW-bit round-robin pointer.
  - On an accept in round-robin mode, ptr <= (g == N-1) ? 0 : g+1.
  - ptr is unchanged in fixed mode and on cycles with no accept.
- A mode or sel change takes effect on the grant in the same cycle. A word already in the output register is never altered by a mode or sel change.
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0. While rst is high, in_ready is all 0.

## Timing
- Latency is 1 cycle. A word accepted at edge k appears on out_data/out_valid after edge k.
- Throughput is 1 word per cycle when out_ready is held high.
- With all N channels valid continuously in round-robin mode, the grant order is 0,1,…,N-1,0,… Each channel waits at most N-1 accepts.
- Reset mid-transfer: a word in the output register is discarded. Producers must treat a rst cycle as non-accept.
- in_ready is combinational from in_valid, mode, sel, out_valid, out_ready and ptr. No output depends combinationally on in_data.

## Test plan
- Reset: hold rst for 2 cycles with all inputs valid. Required: out_valid=0, out_data=0, out_ch=0, in_ready=0. On the first cycle after rst falls, in round-robin mode, channel 0 is granted.
- Fixed mode, N=4, W=1: apply data 0,1,0,1 on channels 0..3, all valid, out_ready=1, and step sel 0,1,2,3 every cycle. Required: out_data follows 0,1,0,1 one cycle later, and out_ch follows 0,1,2,3.
- Round-robin fairness, N=4, W=8: channel i constantly offers data 8'hA0+i, all valid, out_ready=1. Required: out_ch sequence 0,1,2,3,0,1, data A0,A1,A2,A3,A0, one word per cycle.
- Sparse and wrap: only channels 1 and 3 valid, with ptr=2 after accepting channel 1. Required: next grant is 3, then 1. ptr goes 0 → 2 → 0 → 2.
- Backpressure: hold out_ready=0 for 3 cycles with a word loaded. Required: out_data and out_ch stay stable, in_ready=0. Raise out_ready with channel 2 valid. Required: drain and new load happen on the same edge and out_valid stays 1.
- Fixed mode with sel=2 and in_valid[2]=0, others valid: no accept and out_valid falls after the drain. Then assert rst while out_valid=1. Required: out_valid=0 and ptr=0 on the next edge.
